// File: rtl/alu_pin_driver.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_pin_driver : drives {op,a,b} onto the ALU pins, waits for the result to
// settle, samples uo_out and returns it on a valid/ready response port.
// Rev 1.0
// ----------------------------------------------------------------------------
module alu_pin_driver #(
  parameter int SETTLE_CYCLES = 2,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [3:0]       cmd_op,
  input  logic [3:0]       cmd_a,
  input  logic [3:0]       cmd_b,
  input  logic [7:0]       cmd_exp,
  input  logic             cmd_chk,
  output logic [7:0]       alu_ui_in,
  output logic [7:0]       alu_uio_in,
  output logic             alu_ena,
  input  logic [7:0]       alu_uo_out,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [7:0]       rsp_data,
  output logic             rsp_mismatch,
  output logic [7:0]       err_count,
  output logic [CNT_W-1:0] txn_count
);

  // A zero settle time still needs one cycle for the pins to reach the ALU.
  localparam int SETTLE_EFF = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
  localparam int SCNT_W     = (SETTLE_EFF > 1) ? $clog2(SETTLE_EFF) : 1;
  localparam logic [SCNT_W-1:0] SETTLE_LAST = SCNT_W'(SETTLE_EFF - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_RESP   = 2'd2;

  logic [1:0]        state;
  logic [1:0]        state_next;
  logic [SCNT_W-1:0] settle_cnt;
  logic              chk_q;
  logic [7:0]        exp_q;
  logic              accept;
  logic              sample;
  logic              rsp_done;
  logic              mismatch;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:   if (cmd_valid && cmd_ready)      state_next = ST_SETTLE;
      ST_SETTLE: if (settle_cnt == SETTLE_LAST)   state_next = ST_RESP;
      ST_RESP:   if (rsp_valid && rsp_ready)      state_next = ST_IDLE;
      default:                                    state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    accept   = 1'b0;
    sample   = 1'b0;
    rsp_done = 1'b0;
    case (state)
      ST_IDLE:   accept   = cmd_valid & cmd_ready;
      ST_SETTLE: sample   = (settle_cnt == SETTLE_LAST);
      ST_RESP:   rsp_done = rsp_valid & rsp_ready;
      default: ;
    endcase
  end

  assign mismatch = chk_q & (alu_uo_out != exp_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready    <= 1'b0;
      alu_ui_in    <= 8'h00;
      alu_uio_in   <= 8'h00;
      alu_ena      <= 1'b0;
      rsp_valid    <= 1'b0;
      rsp_data     <= 8'h00;
      rsp_mismatch <= 1'b0;
      err_count    <= 8'h00;
      txn_count    <= '0;
      settle_cnt   <= '0;
      chk_q        <= 1'b0;
      exp_q        <= 8'h00;
    end else begin
      alu_ena   <= 1'b1;
      cmd_ready <= (state_next == ST_IDLE);

      if (accept) begin
        // Pins are only ever updated here, so the ALU holds the last operands.
        alu_ui_in  <= {cmd_a, cmd_b};
        alu_uio_in <= {4'b0000, cmd_op};
        chk_q      <= cmd_chk;
        exp_q      <= cmd_exp;
        settle_cnt <= '0;
      end else if (state == ST_SETTLE) begin
        settle_cnt <= settle_cnt + SCNT_W'(1);
      end

      if (sample) begin
        rsp_data     <= alu_uo_out;
        rsp_mismatch <= mismatch;
        rsp_valid    <= 1'b1;
        txn_count    <= txn_count + CNT_W'(1);
        if (mismatch && (err_count != 8'hFF)) begin
          err_count <= err_count + 8'd1;
        end
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire
